// File: rtl/fp_pkg.sv
// fp_pkg: op codes, canonical NaN and FSM state shared by the FP ALU
// scheduler and its arbiter.
package fp_pkg;

  localparam logic [3:0] FP_ADD     = 4'd0;
  localparam logic [3:0] FP_SUB     = 4'd1;
  localparam logic [3:0] FP_MUL     = 4'd2;
  localparam logic [3:0] FP_ILL3    = 4'd3;
  localparam logic [3:0] FP_MIN     = 4'd4;
  localparam logic [3:0] FP_MAX     = 4'd5;
  localparam logic [3:0] FP_SGNJ    = 4'd6;
  localparam logic [3:0] FP_SGNJN   = 4'd7;
  localparam logic [3:0] FP_SGNJX   = 4'd8;
  localparam logic [3:0] FP_EQ      = 4'd9;
  localparam logic [3:0] FP_LT      = 4'd10;
  localparam logic [3:0] FP_LE      = 4'd11;
  localparam logic [3:0] FP_CVT_W_S = 4'd12;
  localparam logic [3:0] FP_CLASS   = 4'd13;
  localparam logic [3:0] FP_CVT_S_W = 4'd14;
  localparam logic [3:0] FP_ILL15   = 4'd15;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } fp_state_e;

  function automatic logic fp_illegal(input logic [3:0] op);
    return (op == FP_ILL3) || (op == FP_ILL15);
  endfunction

endpackage

// File: rtl/fp_alu_sched_arb.sv
// fp_sched_arb: two-port request arbiter.
// FP_SCHED_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module fp_sched_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef FP_SCHED_RR_EN
  // ptr_q names the port preferred on a tie
  logic ptr_q;
  logic ptr_d;

  assign ptr_d = advance ? ~ptr_q : ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) begin
        grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset, advance};

  always_comb begin
    grant = 2'b00;
    if (en) begin
      grant = valid[0] ? 2'b01 : valid;
    end
  end
`endif

endmodule

// File: rtl/fp_alu_sched.sv
// fp_alu_sched: shares one combinational FP ALU between two requesters.
// Arbitration mode is selected by FP_SCHED_RR_EN (see fp_sched_arb).
module fp_alu_sched
  import fp_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 3,
  parameter int unsigned LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic        req_su0,
  input  logic        req_su1,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [3:0]  alu_control,
  output logic        alu_s_u,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);

  localparam int CW = 8;

  function automatic logic [CW-1:0] lat_m1(input logic [3:0] op);
    int unsigned l;
    case (op)
      FP_ADD, FP_SUB: l = LAT_ADD;
      FP_MUL:         l = LAT_MUL;
      default:        l = LAT_MISC;
    endcase
    return CW'(l - 1);
  endfunction

  fp_state_e   state_q;
  logic        port_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  op_q;
  logic        su_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        err_q;

  logic [1:0]  grant;
  logic        arb_en;
  logic        accept;
  logic [3:0]  op_d;
  logic        su_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  assign arb_en = (state_q == S_IDLE) && !reset;
  assign accept = |grant;

  fp_sched_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (req_valid),
    .en      (arb_en),
    .advance (accept),
    .grant   (grant)
  );

  assign op_d = grant[1] ? req_op1 : req_op0;
  assign su_d = grant[1] ? req_su1 : req_su0;
  assign a_d  = grant[1] ? req_a1  : req_a0;
  assign b_d  = grant[1] ? req_b1  : req_b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      su_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            port_q <= grant[1];
            op_q   <= op_d;
            su_q   <= su_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= lat_m1(op_d);
            // Illegal ops never reach the ALU
            if (fp_illegal(op_d)) begin
              res_q   <= FP_QNAN;
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              state_q <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            res_q   <= alu_result;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[port_q]) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = (state_q == S_RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result  = res_q;
  assign rsp_err     = err_q;
  assign alu_control = op_q;
  assign alu_s_u     = su_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;

endmodule

// File: tb/tb_fp_alu_sched.sv
// tb_fp_alu_sched: directed and randomized checks of fp_alu_sched
// against a transaction-level reference model and a stand-in ALU.
module tb_fp_alu_sched;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic        req_su0, req_su1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [3:0]  alu_control;
  logic        alu_s_u;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;

  int tests = 0;
  int fails = 0;
  bit rr_ptr = 1'b0;

  always #5 clk = ~clk;

  fp_alu_sched dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .req_su0     (req_su0),
    .req_su1     (req_su1),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .alu_control (alu_control),
    .alu_s_u     (alu_s_u),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result)
  );

  // Stand-in ALU: exact values for the directed FP vectors, a mix otherwise
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic su,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      4'd1:  return a - b;
      4'd2:  return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : a * b;
      4'd14: return (!su && a == 32'hFFFFFFFF) ? 32'hBF800000 : {a[15:0], b[15:0]} ^ {31'd0, su};
      default: return a ^ {b[15:0], b[31:16]} ^ {28'd0, op} ^ {su, 31'd0};
    endcase
  endfunction

  assign alu_result = alu_f(alu_control, alu_s_u, alu_a, alu_b);

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd3 || op == 4'd15) return 0;
    if (op == 4'd0 || op == 4'd1) return 2;
    if (op == 4'd2) return 3;
    return 1;
  endfunction

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
`ifdef FP_SCHED_RR_EN
    if (v == 2'b11) return rr_ptr ? 2'b10 : 2'b01;
    return v;
`else
    return v[0] ? 2'b01 : v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic su,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req_op0 = op; req_su0 = su; req_a0 = a; req_b0 = b;
    end else begin
      req_op1 = op; req_su1 = su; req_a1 = a; req_b1 = b;
    end
    req_valid[p] = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, req_ready, 0);
    chk({tag, "_vld"}, rsp_valid, 0);
    chk({tag, "_res"}, rsp_result, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_ctl"}, alu_control, 0);
    chk({tag, "_su"}, alu_s_u, 0);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
  endtask

  // Called at a negedge in IDLE; returns the accepted port
  task automatic issue(output int p);
    logic [1:0] g;
    g = exp_grant(req_valid);
    chk("grant", req_ready, g);
    p = g[1] ? 1 : 0;
    @(posedge clk);
    if (g != 2'b00) rr_ptr = ~rr_ptr;
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic wait_resp(input int p, input logic [3:0] op, input logic su,
                           input logic [31:0] a, input logic [31:0] b, input int hold);
    int k;
    logic [31:0] er;
    logic ee;
    ee = (op == 4'd3 || op == 4'd15);
    er = ee ? 32'h7FC00000 : alu_f(op, su, a, b);
    k = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && k < 20) begin
      chk("exec_a", alu_a, a);
      chk("exec_b", alu_b, b);
      chk("exec_ctl", alu_control, op);
      chk("exec_su", alu_s_u, su);
      chk("exec_rdy", req_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, exp_lat(op));
    chk("rsp_valid", rsp_valid, 2'b01 << p);
    chk("rsp_result", rsp_result, er);
    chk("rsp_err", rsp_err, ee);
    rsp_ready = (p == 0) ? 2'b10 : 2'b01;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 2'b01 << p);
      chk("hold_result", rsp_result, er);
      chk("hold_err", rsp_err, ee);
      chk("hold_rdy", req_ready, 0);
    end
    rsp_ready = (p == 0) ? 2'b01 : 2'b10;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 0);
  endtask

  task automatic run_one(input int p, input logic [3:0] op, input logic su,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
    int q;
    @(negedge clk);
    set_req(p, op, su, a, b);
    #1 issue(q);
    chk("port", q, p);
    wait_resp(p, op, su, a, b, hold);
  endtask

  initial begin
    int p;
    int order[$];
    int exp_order[$];
    logic [3:0]  qop [2][$];
    logic [31:0] qa [2][$];
    logic [31:0] qb [2][$];
    bit pend [2];
    logic [3:0]  rop [2];
    logic        rsu [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    bit start;

    reset = 1'b1;
    rsp_ready = 2'b00;
    set_req(0, 4'd0, 1'b0, 32'h1, 32'h2);
    set_req(1, 4'd2, 1'b0, 32'h3, 32'h4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    req_valid = 2'b00;
    reset = 1'b0;
    rr_ptr = 1'b0;

    run_one(0, 4'd0, 1'b0, 32'h3F800000, 32'h40000000, 0);
    run_one(1, 4'd2, 1'b0, 32'h40000000, 32'h40400000, 3);
    run_one(0, 4'd3, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1);
    run_one(0, 4'd14, 1'b0, 32'hFFFFFFFF, 32'h0, 0);
    run_one(1, 4'd15, 1'b1, 32'h0, 32'h1, 0);

    // Both ports busy with four ops each
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 2; j++) begin
        qop[j].push_back(4'($urandom_range(0, 15)));
        qa[j].push_back($urandom);
        qb[j].push_back($urandom);
      end
    end
    start = rr_ptr;
    for (int i = 0; i < 8; i++) begin
`ifdef FP_SCHED_RR_EN
      exp_order.push_back(int'(start ^ i[0]));
`else
      exp_order.push_back(i < 4 ? 0 : 1);
`endif
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (qop[j].size() != 0) set_req(j, qop[j][0], 1'b0, qa[j][0], qb[j][0]);
      end
      #1 issue(p);
      order.push_back(p);
      wait_resp(p, qop[p][0], 1'b0, qa[p][0], qb[p][0], i % 2);
      void'(qop[p].pop_front());
      void'(qa[p].pop_front());
      void'(qb[p].pop_front());
    end
    for (int i = 0; i < 8; i++) chk($sformatf("order%0d", i), order[i], exp_order[i]);

    // Reset mid-EXEC of a mul drops the operation
    @(negedge clk);
    set_req(0, 4'd2, 1'b0, 32'h40000000, 32'h40400000);
    #1 issue(p);
    @(negedge clk);
    chk("midexec_a", alu_a, 32'h40000000);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    reset = 1'b0;
    rr_ptr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp", rsp_valid, 0);
    end
    run_one(1, 4'd0, 1'b0, 32'h3F800000, 32'h40000000, 0);

    // Randomized traffic; a waiting requester keeps its request stable
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!pend[j] && $urandom_range(0, 3) != 0) begin
          pend[j] = 1'b1;
          rop[j] = 4'($urandom_range(0, 15));
          rsu[j] = 1'($urandom_range(0, 1));
          ra[j] = $urandom;
          rb[j] = $urandom;
          set_req(j, rop[j], rsu[j], ra[j], rb[j]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        @(negedge clk);
        chk("idle_rdy", req_ready, 0);
        continue;
      end
      #1 issue(p);
      pend[p] = 1'b0;
      wait_resp(p, rop[p], rsu[p], ra[p], rb[p], $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
